// File: rtl/imem_fetch_responder.sv
`default_nettype none
// ============================================================================
// Module   : imem_fetch_responder
// Purpose  : Instruction-memory responder for the fetch stage. Accepts PC
//            requests over valid/ready, reads a synchronous word-addressed
//            memory and returns {instr, addr, fault} in request order through
//            a 2-entry response FIFO. Flush drops everything in flight; a
//            write port loads the program image at run time.
// Revision : 1.0 - initial release
// ============================================================================
module imem_fetch_responder #(
   parameter int          IMEM_DEPTH = 256,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic        flush,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_instr,
   output logic [31:0] rsp_addr,
   output logic        rsp_fault,
   input  logic        wr_en,
   input  logic [31:0] wr_addr,
   input  logic [31:0] wr_data
);

   localparam int          c_IDX_W = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
   localparam logic [31:0] c_DEPTH = 32'(IMEM_DEPTH);

   // Program memory; contents deliberately survive reset.
   logic [31:0] r_mem [IMEM_DEPTH];

   // Stage 1: the request accepted at the previous edge, data already read.
   logic        r_s1_valid;
   logic        r_s1_fault;
   logic [31:0] r_s1_addr;
   logic [31:0] r_s1_data;

   // 2-entry response FIFO.
   logic [31:0] r_fifo_instr [2];
   logic [31:0] r_fifo_addr  [2];
   logic [1:0]  r_fifo_fault;
   logic        r_wr_ptr;
   logic        r_rd_ptr;
   logic [1:0]  r_count;

   logic [31:0]        w_req_off;
   logic               w_req_fault;
   logic [c_IDX_W-1:0] w_req_idx;
   logic [31:0]        w_wr_off;
   logic               w_wr_ok;
   logic [c_IDX_W-1:0] w_wr_idx;
   logic [1:0]         w_occ;
   logic               w_accept;
   logic               w_push;
   logic               w_pop;

   // Request decode. BASE_ADDR is expected word-aligned, so checking both the
   // raw and the relative low bits only differs for a misconfigured base.
   assign w_req_off   = req_addr - BASE_ADDR;
   assign w_req_fault = (req_addr[1:0] != 2'b00) || (w_req_off[1:0] != 2'b00)
                     || (req_addr < BASE_ADDR)
                     || ({2'b00, w_req_off[31:2]} >= c_DEPTH);
   assign w_req_idx   = w_req_off[c_IDX_W+1:2];

   // Write decode: misaligned or out-of-range writes are dropped, never wrapped.
   assign w_wr_off = wr_addr - BASE_ADDR;
   assign w_wr_ok  = wr_en && (wr_addr[1:0] == 2'b00) && (w_wr_off[1:0] == 2'b00)
                  && (wr_addr >= BASE_ADDR)
                  && ({2'b00, w_wr_off[31:2]} < c_DEPTH);
   assign w_wr_idx = w_wr_off[c_IDX_W+1:2];

   // Credits: a read in flight plus buffered responses never exceed two, so
   // the FIFO can always absorb the read that is in flight.
   assign w_occ     = {1'b0, r_s1_valid} + r_count;
   assign req_ready = (w_occ < 2'd2) && !flush;
   assign w_accept  = req_valid && req_ready;
   assign w_push    = r_s1_valid;
   assign w_pop     = rsp_valid && rsp_ready;

   // Response outputs come from the FIFO head and read as zero while empty.
   assign rsp_valid = (r_count != 2'd0);
   assign rsp_instr = rsp_valid ? r_fifo_instr[r_rd_ptr] : 32'h0;
   assign rsp_addr  = rsp_valid ? r_fifo_addr[r_rd_ptr]  : 32'h0;
   assign rsp_fault = rsp_valid ? r_fifo_fault[r_rd_ptr] : 1'b0;

   // Program-load port; the non-blocking write makes a same-edge read see old data.
   always_ff @(posedge clk) begin
      if (w_wr_ok) begin
         r_mem[w_wr_idx] <= wr_data;
      end
   end

   // Capture the accepted request and read memory on the accept edge.
   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         r_s1_valid <= 1'b0;
         r_s1_fault <= 1'b0;
         r_s1_addr  <= 32'h0;
         r_s1_data  <= 32'h0;
      end else begin
         r_s1_valid <= w_accept;
         if (w_accept) begin
            r_s1_addr  <= req_addr;
            r_s1_fault <= w_req_fault;
            r_s1_data  <= w_req_fault ? NOP_INSTR : r_mem[w_req_idx];
         end
      end
   end

   // FIFO storage; contents are only observed through the valid-gated outputs.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_instr[r_wr_ptr] <= r_s1_data;
         r_fifo_addr[r_wr_ptr]  <= r_s1_addr;
         r_fifo_fault[r_wr_ptr] <= r_s1_fault;
      end
   end

   // FIFO pointers and count; flush and reset empty it and win over push/pop.
   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_imem_fetch_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_fetch_responder
// Purpose  : Self-checking bench for imem_fetch_responder: table of fetch
//            vectors plus hand sequences for back-pressure, flush, read-first
//            writes and mid-run reset, with a response scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_fetch_responder;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n, req_valid, req_ready, flush;
   logic        rsp_valid, rsp_ready, rsp_fault, wr_en;
   logic [31:0] req_addr, rsp_instr, rsp_addr, wr_addr, wr_data;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] addr;
      logic        fault;
   } rsp_t;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] instr;
      logic        fault;
   } vec_t;

   rsp_t exp_q[$];
   vec_t vecs[10];
   int   checks   = 0;
   int   failures = 0;

   imem_fetch_responder #(
      .IMEM_DEPTH(256),
      .BASE_ADDR (32'h0000_0000),
      .NOP_INSTR (NOP)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_addr (req_addr),
      .flush    (flush),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_instr(rsp_instr),
      .rsp_addr (rsp_addr),
      .rsp_fault(rsp_fault),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Scoreboard: every handshake that completes a pop is compared in order.
   always @(negedge clk) begin
      if (rst_n && !flush && rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_rsp: got addr %h instr %h expected no response", rsp_addr, rsp_instr);
         end else begin
            rsp_t e;
            e = exp_q.pop_front();
            check("rsp_instr", rsp_instr, e.instr);
            check("rsp_addr", rsp_addr, e.addr);
            check("rsp_fault", {31'b0, rsp_fault}, {31'b0, e.fault});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      tick();
      wr_en = 1'b0;
   endtask

   // Holds req_valid until accepted (bounded); leaves req_valid asserted.
   task automatic issue(input logic [31:0] addr, input logic [31:0] instr, input logic fault);
      rsp_t e;
      bit   done;
      done = 1'b0;
      req_valid = 1'b1; req_addr = addr;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         if (req_ready) begin
            e.instr = instr; e.addr = addr; e.fault = fault;
            exp_q.push_back(e);
            done = 1'b1;
         end
         tick();
      end
      if (!done) begin
         checks++;
         failures++;
         $display("FAIL issue_timeout: addr %h ready %b expected 1", addr, req_ready);
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 30 && exp_q.size() != 0; i++) @(negedge clk);
      check("drain_empty", 32'(exp_q.size()), 32'd0);
      tick();
      @(negedge clk);
      check("drain_idle_valid", {31'b0, rsp_valid}, 32'd0);
      tick();
   endtask

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_addr = 32'h0; flush = 1'b0;
      rsp_ready = 1'b1; wr_en = 1'b0; wr_addr = 32'h0; wr_data = 32'h0;

      // Reset state
      tick(); tick();
      @(negedge clk);
      check("rst_valid", {31'b0, rsp_valid}, 32'd0);
      check("rst_instr", rsp_instr, 32'h0);
      check("rst_addr", rsp_addr, 32'h0);
      check("rst_fault", {31'b0, rsp_fault}, 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      @(negedge clk);
      check("ready_after_rst", {31'b0, req_ready}, 32'd1);
      tick();

      // Program image, including writes that must be ignored
      wr(32'h00, 32'h11); wr(32'h04, 32'h22); wr(32'h08, 32'h33); wr(32'h0C, 32'h44);
      wr(32'h14, 32'h55); wr(32'h20, 32'h88); wr(32'h3FC, 32'hAA55_AA55);
      wr(32'h22, 32'h0000_0BAD);   // misaligned
      wr(32'h400, 32'h0000_0BAD);  // one past the end

      // Single fetch latency: visible after the second edge, not the first
      issue(32'h0, 32'h11, 1'b0);
      req_valid = 1'b0;
      @(negedge clk);
      check("lat_not_early", {31'b0, rsp_valid}, 32'd0);
      tick();
      @(negedge clk);
      check("lat_one_cycle", {31'b0, rsp_valid}, 32'd1);
      tick();
      drain();

      // Table-driven stream: in-order data, boundary word and fault cases
      vecs[0] = '{addr: 32'h0,         instr: 32'h11,         fault: 1'b0};
      vecs[1] = '{addr: 32'h4,         instr: 32'h22,         fault: 1'b0};
      vecs[2] = '{addr: 32'h8,         instr: 32'h33,         fault: 1'b0};
      vecs[3] = '{addr: 32'hC,         instr: 32'h44,         fault: 1'b0};
      vecs[4] = '{addr: 32'h20,        instr: 32'h88,         fault: 1'b0};
      vecs[5] = '{addr: 32'h3FC,       instr: 32'hAA55_AA55,  fault: 1'b0};
      vecs[6] = '{addr: 32'h2,         instr: NOP,            fault: 1'b1};
      vecs[7] = '{addr: 32'h400,       instr: NOP,            fault: 1'b1};
      vecs[8] = '{addr: 32'hFFFF_FFFC, instr: NOP,            fault: 1'b1};
      vecs[9] = '{addr: 32'h401,       instr: NOP,            fault: 1'b1};
      for (int v = 0; v < 10; v++) begin
         issue(vecs[v].addr, vecs[v].instr, vecs[v].fault);
      end
      req_valid = 1'b0;
      drain();

      // Back-pressure: two credits, head holds while stalled
      rsp_ready = 1'b0;
      issue(32'h0, 32'h11, 1'b0);
      issue(32'h4, 32'h22, 1'b0);
      req_valid = 1'b0;
      @(negedge clk);
      check("bp_ready_low", {31'b0, req_ready}, 32'd0);
      tick();
      tick();
      @(negedge clk);
      check("bp_valid", {31'b0, rsp_valid}, 32'd1);
      check("bp_head_hold", rsp_instr, 32'h11);
      tick();
      rsp_ready = 1'b1;
      drain();
      @(negedge clk);
      check("bp_ready_again", {31'b0, req_ready}, 32'd1);
      tick();

      // Flush with two pending and a same-cycle request
      rsp_ready = 1'b0;
      issue(32'h0, 32'h11, 1'b0);
      issue(32'h4, 32'h22, 1'b0);
      req_addr = 32'h8; req_valid = 1'b1; flush = 1'b1;
      @(negedge clk);
      check("flush_ready_low", {31'b0, req_ready}, 32'd0);
      tick();
      flush = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
      exp_q.delete();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("flush_no_rsp", {31'b0, rsp_valid}, 32'd0);
         tick();
      end
      issue(32'h8, 32'h33, 1'b0);
      req_valid = 1'b0;
      drain();

      // Read-first: write and fetch of word 5 on the same edge
      wr_en = 1'b1; wr_addr = 32'h14; wr_data = 32'hDEAD_BEEF;
      issue(32'h14, 32'h55, 1'b0);
      wr_en = 1'b0;
      issue(32'h14, 32'hDEAD_BEEF, 1'b0);
      req_valid = 1'b0;
      drain();

      // Reset with two fetches pending; memory must survive
      rsp_ready = 1'b0;
      issue(32'h0, 32'h11, 1'b0);
      issue(32'h4, 32'h22, 1'b0);
      req_valid = 1'b0; rst_n = 1'b0;
      tick();
      exp_q.delete();
      @(negedge clk);
      check("midrst_valid", {31'b0, rsp_valid}, 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      @(negedge clk);
      check("midrst_ready", {31'b0, req_ready}, 32'd1);
      check("midrst_valid2", {31'b0, rsp_valid}, 32'd0);
      tick();
      rsp_ready = 1'b1;
      issue(32'h0, 32'h11, 1'b0);
      issue(32'h14, 32'hDEAD_BEEF, 1'b0);
      issue(32'h3FC, 32'hAA55_AA55, 1'b0);
      req_valid = 1'b0;
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
